// File: rtl/map_tile_scanner.sv
// Raster-walks a map grid, fetches tile IDs from BRAM, overlays sprite tiles
// and streams (tile, x, y) descriptors to the renderer over valid/ready.
module map_tile_scanner #(
    parameter int MAP_W      = 13,
    parameter int MAP_H      = 13,
    parameter int COORD_W    = 4,
    parameter int N_SPR      = 4,
    parameter int TILE_W     = 16,
    parameter int ADDR_W     = 19,
    parameter int MAPID_W    = 8,
    parameter int MAP_STRIDE = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [MAPID_W-1:0]         map_id,
    input  logic [N_SPR-1:0]           spr_en,
    input  logic [N_SPR*COORD_W-1:0]   spr_x,
    input  logic [N_SPR*COORD_W-1:0]   spr_y,
    input  logic [N_SPR*TILE_W-1:0]    spr_tile,
    output logic [ADDR_W-1:0]          bram_addr,
    input  logic [TILE_W-1:0]          bram_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TILE_W-1:0]          out_tile,
    output logic [COORD_W-1:0]         out_x,
    output logic [COORD_W-1:0]         out_y,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {IDLE, SEEK, FETCH, WAIT, EMIT, FIN} state_t;

    state_t                   state, state_nxt;
    logic                     mode_q;
    logic [ADDR_W-1:0]        base_q;
    logic [N_SPR-1:0]         en_q;
    logic [N_SPR*COORD_W-1:0] sx_q, sy_q;
    logic [N_SPR*TILE_W-1:0]  st_q;
    logic [COORD_W-1:0]       x, y;
    logic                     hit, last, go, advance;
    logic [TILE_W-1:0]        hit_tile;
    logic [ADDR_W-1:0]        cell_addr;

    assign last = (x == COORD_W'(MAP_W - 1)) && (y == COORD_W'(MAP_H - 1));
    assign go   = !mode_q || hit;
    assign cell_addr = base_q + ADDR_W'(32'(y) * 32'(MAP_W) + 32'(x));

    // Scan from the top index down so the lowest-index hit wins.
    always_comb begin
        hit      = 1'b0;
        hit_tile = '0;
        for (int k = N_SPR - 1; k >= 0; k--) begin
            if (en_q[k] && sx_q[k*COORD_W +: COORD_W] == x &&
                sy_q[k*COORD_W +: COORD_W] == y) begin
                hit      = 1'b1;
                hit_tile = st_q[k*TILE_W +: TILE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEEK;
            SEEK:    if (go) state_nxt = FETCH;
                     else if (last) state_nxt = FIN;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last ? FIN : SEEK;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SEEK) || (state == FETCH) ||
               (state == WAIT) || (state == EMIT);
        done = (state == FIN);
    end

    assign advance = (state == SEEK && !go && !last) ||
                     (state == EMIT && out_ready && !last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            base_q    <= '0;
            en_q      <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            st_q      <= '0;
            x         <= '0;
            y         <= '0;
            bram_addr <= '0;
            out_valid <= 1'b0;
            out_tile  <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q <= mode;
                base_q <= ADDR_W'(32'(map_id) * 32'(MAP_STRIDE));
                en_q   <= spr_en;
                sx_q   <= spr_x;
                sy_q   <= spr_y;
                st_q   <= spr_tile;
                x      <= '0;
                y      <= '0;
            end else if (advance) begin
                if (x == COORD_W'(MAP_W - 1)) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            // Address settles in SEEK so BRAM samples it at the end of FETCH.
            if (state == SEEK) bram_addr <= cell_addr;
            if (state == WAIT) begin
                out_valid <= 1'b1;
                out_tile  <= hit ? hit_tile : bram_data;
                out_x     <= x;
                out_y     <= y;
            end else if (state == EMIT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_map_tile_scanner.sv
// Directed self-checking bench for map_tile_scanner with a BRAM model
// and a descriptor collector driven from a single initial block.
module tb_map_tile_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  map_id;
    logic [3:0]  spr_en;
    logic [15:0] spr_x, spr_y;
    logic [63:0] spr_tile;
    logic [18:0] bram_addr;
    logic [15:0] bram_data;
    logic        out_valid, out_ready;
    logic [15:0] out_tile;
    logic [3:0]  out_x, out_y;
    logic        busy, done;

    map_tile_scanner dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .map_id(map_id),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_tile(spr_tile),
        .bram_addr(bram_addr), .bram_data(bram_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tile(out_tile),
        .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bram_word(input logic [18:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd7;
        return t[15:0] ^ 16'h3C5A;
    endfunction

    always_ff @(posedge clk) bram_data <= bram_word(bram_addr);

    typedef struct packed {
        logic [15:0] tile;
        logic [3:0]  x;
        logic [3:0]  y;
    } desc_t;

    desc_t got[$];
    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt, unstable, first_valid, hs_cyc, done_cyc, post;
    bit timed_out;

    // Mismatching descriptors against a 13x13 scan of map 2, sprite at (sx,sy)
    function automatic int count_bad(input int sx, input int sy,
                                     input logic [15:0] st);
        int bad = 0;
        desc_t e;
        for (int i = 0; i < got.size() && i < 169; i++) begin
            e.x = 4'(i % 13);
            e.y = 4'(i / 13);
            e.tile = (sx >= 0 && i == sy * 13 + sx) ? st
                     : bram_word(19'(512 + i));
            if (got[i] !== e) bad++;
        end
        return bad;
    endfunction

    task automatic set_spr(input int k, input logic en, input logic [3:0] sx,
                           input logic [3:0] sy, input logic [15:0] st);
        spr_en[k]          = en;
        spr_x[k*4 +: 4]    = sx;
        spr_y[k*4 +: 4]    = sy;
        spr_tile[k*16 +: 16] = st;
    endtask

    task automatic run_scan(input int ready_pct, input int max_cyc,
                            input bit perturb);
        int cyc = 0;
        int after = -1;
        bit stalled = 0;
        bit fin = 0;
        desc_t held = '0;
        got.delete();
        done_cnt = 0; unstable = 0; first_valid = -1;
        hs_cyc = -1; done_cyc = -1; post = 0; timed_out = 0;
        @(negedge clk);
        start = 1'b1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (perturb && cyc == 10) begin
                spr_x[3:0] = 4'd0;
                map_id = 8'd7;
                start = 1'b1;
            end
            if (perturb && cyc == 11) start = 1'b0;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (after < 0) after = cyc;
            end
            if (after >= 0 && cyc > after && busy) post++;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalled && {out_tile, out_x, out_y} !== held) unstable++;
                if (after >= 0) post++;
                if (out_ready) begin
                    got.push_back({out_tile, out_x, out_y});
                    hs_cyc = cyc;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = {out_tile, out_x, out_y};
                end
            end
            if (after >= 0 && cyc >= after + 3) fin = 1;
            if (cyc >= max_cyc) begin
                timed_out = 1;
                fin = 1;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic clear_inputs();
        mode = 1'b0; map_id = 8'd2;
        spr_en = '0; spr_x = '0; spr_y = '0; spr_tile = '0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, want 0 0 0",
                     out_valid, busy, done);
        end
        n_cmp++;
        if ({out_tile, out_x, out_y} !== 24'd0 || bram_addr !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_data: tile=%h x=%0d y=%0d addr=%h, want 0",
                     out_tile, out_x, out_y, bram_addr);
        end
    endtask

    task automatic test_full();
        int bad;
        clear_inputs();
        run_scan(100, 1200, 0);
        bad = count_bad(-1, 0, 16'h0);
        n_cmp++;
        if (timed_out !== 1'b0 || got.size() !== 169) begin
            n_fail++;
            $display("FAIL full_count: got %0d descriptors (timeout=%0d), want 169",
                     got.size(), timed_out);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL full_data: %0d bad descriptors, want 0", bad);
        end
        n_cmp++;
        if (first_valid !== 4) begin
            n_fail++;
            $display("FAIL full_latency: first valid at %0d, want 4", first_valid);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc - hs_cyc !== 1) begin
            n_fail++;
            $display("FAIL full_done: pulses=%0d gap=%0d, want 1 and 1",
                     done_cnt, done_cyc - hs_cyc);
        end
        n_cmp++;
        if (post !== 0) begin
            n_fail++;
            $display("FAIL full_idle: %0d activity after done, want 0", post);
        end
    endtask

    task automatic test_sprite();
        int bad;
        clear_inputs();
        set_spr(0, 1'b1, 4'd3, 4'd5, 16'h0042);
        set_spr(3, 1'b1, 4'd13, 4'd0, 16'h0777);
        run_scan(100, 1200, 0);
        bad = count_bad(3, 5, 16'h0042);
        n_cmp++;
        if (got.size() !== 169 || bad !== 0) begin
            n_fail++;
            $display("FAIL sprite_single: n=%0d bad=%0d, want 169 and 0",
                     got.size(), bad);
        end
        set_spr(2, 1'b1, 4'd3, 4'd5, 16'h0099);
        run_scan(100, 1200, 0);
        n_cmp++;
        if (got.size() !== 169 || got[68].tile !== 16'h0042) begin
            n_fail++;
            $display("FAIL sprite_priority: n=%0d tile=%h, want 169 and 0042",
                     got.size(), got.size() > 68 ? got[68].tile : 16'hxxxx);
        end
        bad = count_bad(3, 5, 16'h0042);
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL sprite_dup_data: %0d bad descriptors, want 0", bad);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        clear_inputs();
        run_scan(30, 8000, 0);
        bad = count_bad(-1, 0, 16'h0);
        n_cmp++;
        if (timed_out !== 1'b0 || got.size() !== 169 || bad !== 0) begin
            n_fail++;
            $display("FAIL bp_stream: n=%0d bad=%0d timeout=%0d, want 169 0 0",
                     got.size(), bad, timed_out);
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d changes while stalled, want 0", unstable);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL bp_done: %0d done pulses, want 1", done_cnt);
        end
    endtask

    task automatic test_incremental();
        desc_t e0, e1;
        clear_inputs();
        mode = 1'b1;
        set_spr(0, 1'b1, 4'd0, 4'd0, 16'h0011);
        set_spr(1, 1'b0, 4'd4, 4'd4, 16'h0044);
        set_spr(2, 1'b1, 4'd12, 4'd12, 16'h0022);
        set_spr(3, 1'b1, 4'd15, 4'd15, 16'h0033);
        run_scan(100, 1200, 0);
        e0 = {16'h0011, 4'd0, 4'd0};
        e1 = {16'h0022, 4'd12, 4'd12};
        n_cmp++;
        if (got.size() !== 2) begin
            n_fail++;
            $display("FAIL inc_count: %0d descriptors, want 2", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== e0 || got[1] !== e1) begin
                n_fail++;
                $display("FAIL inc_data: %h %h, want %h %h",
                         got[0], got[1], e0, e1);
            end
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc - hs_cyc !== 1) begin
            n_fail++;
            $display("FAIL inc_done: pulses=%0d gap=%0d, want 1 and 1",
                     done_cnt, done_cyc - hs_cyc);
        end
        spr_en = '0;
        run_scan(100, 1200, 0);
        n_cmp++;
        if (timed_out !== 1'b0 || got.size() !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL inc_empty: n=%0d done=%0d timeout=%0d, want 0 1 0",
                     got.size(), done_cnt, timed_out);
        end
    endtask

    task automatic test_snapshot();
        int bad;
        clear_inputs();
        set_spr(0, 1'b1, 4'd3, 4'd5, 16'h0042);
        run_scan(100, 1200, 1);
        bad = count_bad(3, 5, 16'h0042);
        n_cmp++;
        if (got.size() !== 169 || bad !== 0) begin
            n_fail++;
            $display("FAIL snap_data: n=%0d bad=%0d, want 169 and 0",
                     got.size(), bad);
        end
        n_cmp++;
        if (done_cnt !== 1 || post !== 0) begin
            n_fail++;
            $display("FAIL snap_restart: done=%0d post=%0d, want 1 and 0",
                     done_cnt, post);
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        int dn = 0;
        int bad;
        clear_inputs();
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_reach: valid=%b after %0d cycles, want 1",
                     out_valid, waited);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bram_addr !== 19'd0) begin
            n_fail++;
            $display("FAIL rstmid_abort: valid=%b busy=%b addr=%h, want 0 0 0",
                     out_valid, busy, bram_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_cmp++;
        if (dn !== 0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: %0d done pulses, want 0", dn);
        end
        run_scan(100, 1200, 0);
        bad = count_bad(-1, 0, 16'h0);
        n_cmp++;
        if (got.size() !== 169 || bad !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL rstmid_rescan: n=%0d bad=%0d done=%0d, want 169 0 1",
                     got.size(), bad, done_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_full();
        test_sprite();
        test_backpressure();
        test_incremental();
        test_snapshot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/map_tile_scanner.md
Name: map_tile_scanner

Overview:
- Parametrised successor of the single-hero map compositor.
- On a start pulse, walks every grid cell of the selected map in raster order and fetches each cell's tile ID from map BRAM.
- Overlays up to N_SPR sprite tiles using a fixed priority, and streams (tile_id, grid_x, grid_y) to the tile renderer over a valid/ready handshake.
- Supports full-redraw and sprite-only (incremental) modes. Emits a done pulse at the end of each scan.

Parameters:
- MAP_W, 13, grid columns (≤ 2^COORD_W)
- MAP_H, 13, grid rows (≤ 2^COORD_W)
- COORD_W, 4, width of each grid coordinate
- N_SPR, 4, number of sprite overlay channels
- TILE_W, 16, tile ID width
- ADDR_W, 19, map BRAM address width
- MAPID_W, 8, map_id width
- MAP_STRIDE, 256, BRAM words reserved per map (≥ MAP_W*MAP_H)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a scan
- mode  in  1  0 = full redraw, 1 = sprite-only cells
- map_id  in  MAPID_W  map to scan; sampled at start
- spr_en  in  N_SPR  per-sprite enable
- spr_x  in  N_SPR*COORD_W  packed sprite columns (sprite k at bits [k*COORD_W +: COORD_W])
- spr_y  in  N_SPR*COORD_W  packed sprite rows
- spr_tile  in  N_SPR*TILE_W  packed sprite tile IDs
- bram_addr  out  ADDR_W  map BRAM read address
- bram_data  in  TILE_W  map BRAM read data; 1-cycle read latency
- out_valid  out  1  tile descriptor valid
- out_ready  in  1  renderer accepts descriptor
- out_tile  out  TILE_W  composited tile ID
- out_x  out  COORD_W  cell column
- out_y  out  COORD_W  cell row
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the last descriptor is accepted

Behaviour:
- Reset values (asynchronous, while rst is high):
  - state = IDLE
  - busy = 0, done = 0, out_valid = 0
  - out_tile = 0, out_x = 0, out_y = 0, bram_addr = 0
  - internal x/y counters = 0
- Snapshot at start: when start = 1 in IDLE, latch map_id, mode and all spr_* inputs. Later changes to these inputs do not affect the scan in progress.
- start is ignored while busy = 1.
- Address: bram_addr = map_id*MAP_STRIDE + y*MAP_W + x, computed at full precision and truncated to ADDR_W. bram_addr is registered.
- Sprite hit: sprite k hits cell (x, y) when spr_en[k] = 1, spr_x[k] = x and spr_y[k] = y (snapshot values). The lowest-index hit wins. With no hit, the tile comes from BRAM.
- FSM:
  - IDLE: on start → SEEK, busy = 1.
  - SEEK: in mode 0, → FETCH. In mode 1, if the current cell has no sprite hit, advance the cell (one per cycle); otherwise → FETCH. If the last cell is passed without a hit → FIN.
  - FETCH: drive bram_addr for the current cell → WAIT.
  - WAIT: BRAM data is valid this cycle. Register out_tile (sprite tile or bram_data), out_x and out_y; set out_valid = 1 → EMIT.
  - EMIT: out_* are held stable while out_valid = 1 and out_ready = 0. When out_valid and out_ready are both 1: clear out_valid. If this was the last cell → FIN; else advance the cell → SEEK.
  - FIN: done = 1 for exactly one cycle, busy = 0 → IDLE.
- Raster order: x increments 0..MAP_W-1; on wrap x = 0 and y increments. The last cell is (MAP_W-1, MAP_H-1).
- Throughput: mode 0 needs at least 4 cycles per cell with out_ready tied high. Latency from start to the first out_valid is 4 cycles (SEEK, FETCH, WAIT, then EMIT with out_valid high).
- Mode 1 with no enabled sprites: no descriptors are emitted; done still pulses once after the walk.
- Duplicate sprite positions: exactly one descriptor is emitted per cell, using the lowest-index sprite.
- Sprites with coordinates off-grid (x ≥ MAP_W or y ≥ MAP_H) never hit and are silently ignored.
- rst asserted mid-scan aborts immediately to the reset values; no done pulse is produced.

Test Plan:
- Mode 0, MAP_W = MAP_H = 13, map_id = 2, no sprites, out_ready = 1 → 169 descriptors in raster order. Each out_tile equals the BRAM model word at 512 + y*13 + x. done pulses once, 1 cycle after the last handshake.
- Mode 0 with sprite 0 enabled at (3,5), tile 0x0042 → the cell (3,5) descriptor is 0x0042 and all other cells come from BRAM. Additionally enable sprite 2 at (3,5), tile 0x0099 → cell (3,5) is still 0x0042.
- Backpressure: pseudo-random out_ready at 30% → out_tile/out_x/out_y stable while stalled, no descriptor lost or duplicated, 169 handshakes total.
- Mode 1 with sprites at (0,0), (12,12) and (4,4) with spr_en[1] = 0 → exactly 2 descriptors, (0,0) then (12,12), followed by one done pulse.
- Change spr_x and map_id mid-scan, and pulse start mid-scan → output matches the start-time snapshot and the extra start is ignored.
- Assert rst during EMIT → out_valid = 0 and busy = 0 immediately, no done pulse; a new start then runs a clean full scan.
